// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Multi-cycle data-memory responder for the MEM stage of a
//               5-stage MIPS pipeline. Each aligned load/store takes a fixed
//               LATENCY of stall cycles. The access is then committed to a
//               synchronous RAM, and the next cycle is a DONE cycle that
//               presents load data and an ack strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state_q;
  logic [3:0]            cnt_q;
  logic [31:0]           dout_q;
  logic [31:0]           ram_q [DEPTH];

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_access;
  logic                  w_aligned;
  logic                  w_req;
  logic                  w_commit;
  logic                  w_unused_addr;

  // Upper address bits fold away: the RAM index wraps.
  assign w_idx         = mem_addr[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^mem_addr[31:ADDR_WIDTH+2];

  assign w_access  = mem_ren | mem_wen;
  assign w_aligned = (mem_addr[1:0] == 2'b00);
  assign w_req     = w_access & w_aligned & ~mem_rst;

  assign mem_dout  = dout_q;
  assign mem_stall = w_req & (state_q != DONE) & ~rst;
  assign mem_ack   = (state_q == DONE) & mem_en & ~rst;
  assign addr_err  = w_access & ~w_aligned & ~rst;

  // Commit strobe: asserted on the edge that enters DONE. A flush or a frozen stage suppresses it.
  always_comb begin
    w_commit = 1'b0;
    if (!mem_rst && mem_en) begin
      case (state_q)
        IDLE:    w_commit = w_req && (LATENCY == 1);
        BUSY:    w_commit = (cnt_q == 4'd1);
        default: w_commit = 1'b0;
      endcase
    end
  end

  // Access sequencer: IDLE -> BUSY (latency countdown) -> DONE, with the registered read on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      dout_q  <= 32'd0;
    end else if (mem_rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_req && mem_en) begin
            if (LATENCY == 1) begin
              state_q <= DONE;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (mem_en) begin
            if (cnt_q == 4'd1) begin
              state_q <= DONE;
              cnt_q   <= 4'd0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
        end
        DONE: begin
          if (mem_en) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
      // Read-before-write: a store on the same edge is not visible here.
      if (w_commit) begin
        dout_q <= ram_q[w_idx];
      end
    end
  end

  // Single write port. It is used only on the commit edge, and never while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && mem_wen) begin
      ram_q[w_idx] <= mem_din;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed bench for data_mem_responder. A transaction-level
//               model (progress count plus word map) predicts outputs every
//               cycle, and literal checks pin the key timing points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int          LAT  = 3;
  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        mem_en   = 1'b1;
  logic        mem_rst  = 1'b0;
  logic        mem_ren  = 1'b0;
  logic        mem_wen  = 1'b0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] mem_din  = 32'd0;
  logic [31:0] mem_dout;
  logic        mem_stall;
  logic        mem_ack;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  // Model state: the word map, the enabled cycles spent on the current access, and whether the DONE cycle has been reached.
  logic [31:0] m_ram [int];
  bit          m_done;
  int          m_prog;
  logic [31:0] m_dout;

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_WIDTH (10),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_rst   (mem_rst),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .mem_stall (mem_stall),
    .mem_ack   (mem_ack),
    .addr_err  (addr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit m_req_now();
    return (mem_ren || mem_wen) && (mem_addr[1:0] == 2'b00) && !mem_rst;
  endfunction

  task automatic model_reset();
    m_done = 1'b0;
    m_prog = 0;
    m_dout = 32'd0;
  endtask

  // Advance the model by one clock edge, using the inputs present at that edge.
  task automatic model_edge();
    int idx;
    idx = int'(mem_addr[11:2]);
    if (rst) begin
      model_reset();
    end else if (mem_rst) begin
      m_done = 1'b0;
      m_prog = 0;
    end else if (m_done) begin
      if (mem_en) begin
        m_done = 1'b0;
        m_prog = 0;
      end
    end else if (m_req_now() && mem_en) begin
      m_prog++;
      if (m_prog >= LAT) begin
        m_dout = m_ram.exists(idx) ? m_ram[idx] : 32'hxxxx_xxxx;
        if (mem_wen) m_ram[idx] = mem_din;
        m_done = 1'b1;
      end
    end
  endtask

  task automatic compare();
    logic e_stall, e_ack, e_err;
    e_err   = (mem_ren || mem_wen) && (mem_addr[1:0] != 2'b00) && !rst;
    e_stall = m_req_now() && !m_done && !rst;
    e_ack   = m_done && mem_en && !rst;
    chk("stall", {31'b0, mem_stall}, {31'b0, e_stall});
    chk("ack",   {31'b0, mem_ack},   {31'b0, e_ack});
    chk("err",   {31'b0, addr_err},  {31'b0, e_err});
    if (!$isunknown(m_dout)) chk("dout", mem_dout, m_dout);
  endtask

  // Hold one request for ncyc cycles with per-cycle enable/flush masks. Compare every cycle and summarise what was observed.
  task automatic run_op(input bit ren, input bit wen, input logic [31:0] addr,
                        input logic [31:0] din, input logic [31:0] en_mask,
                        input logic [31:0] rst_mask, input int ncyc,
                        output int stalls, output int acks, output int errs,
                        output int ack_cyc, output logic [31:0] ack_dout);
    mem_ren  = ren;
    mem_wen  = wen;
    mem_addr = addr;
    mem_din  = din;
    stalls   = 0;
    acks     = 0;
    errs     = 0;
    ack_cyc  = -1;
    ack_dout = 32'hxxxx_xxxx;
    for (int k = 0; k < ncyc; k++) begin
      mem_en  = en_mask[k];
      mem_rst = rst_mask[k];
      @(negedge clk);
      compare();
      if (mem_stall === 1'b1) stalls++;
      if (addr_err === 1'b1) errs++;
      if (mem_ack === 1'b1) begin
        acks++;
        ack_cyc  = k;
        ack_dout = mem_dout;
      end
      @(posedge clk);
      model_edge();
      #1;
    end
    mem_en  = 1'b1;
    mem_rst = 1'b0;
  endtask

  initial begin
    int s, a, e, c;
    logic [31:0] d;
    model_reset();

    // Reset held, with a load request present: every output stays 0.
    mem_ren  = 1'b1;
    mem_addr = 32'h10;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compare();
      chk("rst_stall", {31'b0, mem_stall}, 32'd0);
      chk("rst_dout", mem_dout, 32'd0);
      @(posedge clk);
      model_edge();
      #1;
    end
    rst      = 1'b0;
    mem_ren  = 1'b0;
    mem_addr = 32'd0;

    // Preload known words.
    run_op(0, 1, 32'h10, 32'h0BAD_F00D, ALL1, 0, 4, s, a, e, c, d);
    chk("pre_stalls", 32'(s), 32'd3);
    chk("pre_ack_cyc", 32'(c), 32'd3);
    run_op(0, 1, 32'h20, 32'h55AA_00FF, ALL1, 0, 4, s, a, e, c, d);
    run_op(0, 1, 32'h30, 32'h1111_1111, ALL1, 0, 4, s, a, e, c, d);
    run_op(0, 1, 32'h40, 32'h2222_2222, ALL1, 0, 4, s, a, e, c, d);

    // Test 1: async reset pulse mid-cycle during a load, then a fresh access.
    run_op(1, 0, 32'h10, 32'd0, ALL1, 0, 1, s, a, e, c, d);
    chk("t1_first_stall", 32'(s), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t1_rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("t1_rst_ack",   {31'b0, mem_ack},   32'd0);
    chk("t1_rst_err",   {31'b0, addr_err},  32'd0);
    chk("t1_rst_dout",  mem_dout,           32'd0);
    model_reset();
    #1 rst = 1'b0;
    run_op(1, 0, 32'h10, 32'd0, ALL1, 0, 4, s, a, e, c, d);
    chk("t1_stalls", 32'(s), 32'd3);
    chk("t1_ack_cyc", 32'(c), 32'd3);
    chk("t1_dout", d, 32'h0BAD_F00D);

    // Test 2: store, then a back-to-back load of the same word.
    run_op(0, 1, 32'h10, 32'hDEAD_BEEF, ALL1, 0, 4, s, a, e, c, d);
    chk("t2_st_stalls", 32'(s), 32'd3);
    chk("t2_st_acks", 32'(a), 32'd1);
    chk("t2_st_ack_cyc", 32'(c), 32'd3);
    run_op(1, 0, 32'h10, 32'd0, ALL1, 0, 4, s, a, e, c, d);
    chk("t2_ld_ack_cyc", 32'(c), 32'd3);
    chk("t2_ld_dout", d, 32'hDEAD_BEEF);

    // Test 3: a misaligned store does nothing except raise addr_err.
    run_op(0, 1, 32'h13, 32'hCAFE_F00D, ALL1, 0, 2, s, a, e, c, d);
    chk("t3_stalls", 32'(s), 32'd0);
    chk("t3_acks", 32'(a), 32'd0);
    chk("t3_errs", 32'(e), 32'd2);
    run_op(1, 0, 32'h10, 32'd0, ALL1, 0, 4, s, a, e, c, d);
    chk("t3_dout", d, 32'hDEAD_BEEF);

    // Test 4: load with mem_en low for two BUSY cycles.
    run_op(1, 0, 32'h20, 32'd0, 32'h39, 0, 6, s, a, e, c, d);
    chk("t4_stalls", 32'(s), 32'd5);
    chk("t4_acks", 32'(a), 32'd1);
    chk("t4_ack_cyc", 32'(c), 32'd5);
    chk("t4_dout", d, 32'h55AA_00FF);

    // Test 5: a flush on the commit edge aborts the store.
    run_op(0, 1, 32'h30, 32'h1234_5678, ALL1, 32'h4, 3, s, a, e, c, d);
    chk("t5_stalls", 32'(s), 32'd2);
    chk("t5_acks", 32'(a), 32'd0);
    run_op(0, 0, 32'd0, 32'd0, ALL1, 0, 1, s, a, e, c, d);
    run_op(1, 0, 32'h30, 32'd0, ALL1, 0, 4, s, a, e, c, d);
    chk("t5_dout", d, 32'h1111_1111);

    // Test 6: async reset during BUSY of a store, held across the would-be commit edge.
    run_op(0, 1, 32'h40, 32'hAAAA_5555, ALL1, 0, 2, s, a, e, c, d);
    chk("t6_stalls", 32'(s), 32'd2);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("t6_rst_ack",   {31'b0, mem_ack},   32'd0);
    chk("t6_rst_dout",  mem_dout,           32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mem_wen = 1'b0;
    run_op(1, 0, 32'h40, 32'd0, ALL1, 0, 4, s, a, e, c, d);
    chk("t6_ack_cyc", 32'(c), 32'd3);
    chk("t6_dout", d, 32'h2222_2222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
